// File: rtl/decode_stage_pipe_pkg.sv
// Shared core definitions (package core_pkg): datapath defaults, opcodes,
// immediate-format and ALU-control encodings, and the E-register bubble value.
package core_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned ALUCW_DEF = 3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_e;

  // Replicated across the full E-register width to form a bubble.
  localparam logic BUBBLE = 1'b0;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: fetch-side inputs, writeback port, hazard controls and the
// registered D->E outputs. The stage uses the slave modport.
interface decode_stage_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned ALUCW = 3
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [31:0]      InstrD;
  logic [XLEN-1:0]  PCD, PCPlus4D;
  logic             ValidD, StallD, FlushE;
  logic             RegWriteW;
  logic [AW-1:0]    RDW;
  logic [XLEN-1:0]  ResultW;
  logic             HazardD;
  logic             ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [ALUCW-1:0] ALUControlE;
  logic [XLEN-1:0]  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [AW-1:0]    RS1_E, RS2_E, RD_E;

  modport slave (
    input  InstrD, PCD, PCPlus4D, ValidD, StallD, FlushE, RegWriteW, RDW, ResultW,
    output HazardD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E
  );

  modport master (
    output InstrD, PCD, PCPlus4D, ValidD, StallD, FlushE, RegWriteW, RDW, ResultW,
    input  HazardD, ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
           ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E
  );
endinterface

// File: rtl/Control_Unit.sv
// Main and ALU decoder for the base integer subset (load/store/R/I/branch).
module Control_Unit
  import core_pkg::*;
(
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       ALUSrc,
  output logic       MemWrite,
  output logic       ResultSrc,
  output logic       Branch,
  output logic [2:0] ALUControl
);
  logic [1:0] alu_op;
  logic       unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    RegWrite  = 1'b0;
    ImmSrc    = IMM_I;
    ALUSrc    = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = 1'b0;
    Branch    = 1'b0;
    alu_op    = 2'b00;
    unique case (Op)
      OP_LOAD:   begin RegWrite = 1'b1; ALUSrc = 1'b1; ResultSrc = 1'b1; end
      OP_STORE:  begin ImmSrc = IMM_S; ALUSrc = 1'b1; MemWrite = 1'b1; end
      OP_RTYPE:  begin RegWrite = 1'b1; alu_op = 2'b10; end
      OP_ITYPE:  begin RegWrite = 1'b1; ALUSrc = 1'b1; alu_op = 2'b10; end
      OP_BRANCH: begin ImmSrc = IMM_B; Branch = 1'b1; alu_op = 2'b01; end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    if (alu_op == 2'b01) begin
      ALUControl = ALU_SUB;
    end else if (alu_op == 2'b10) begin
      unique case (funct3)
        3'b000:  ALUControl = (Op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b010:  ALUControl = ALU_SLT;
        3'b110:  ALUControl = ALU_OR;
        3'b111:  ALUControl = ALU_AND;
        default: ALUControl = ALU_ADD;
      endcase
    end
  end
endmodule

// File: rtl/Sign_Extend.sv
// Immediate extraction and sign extension for I, S and B formats.
module Sign_Extend
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     In,
  input  logic [1:0]      ImmSrc,
  output logic [XLEN-1:0] Imm_Ext
);
  logic unused_bits;

  assign unused_bits = ^{In[19:12], In[6:0]};

  always_comb begin
    Imm_Ext = '0;
    unique case (ImmSrc)
      IMM_I:   Imm_Ext = {{(XLEN-12){In[31]}}, In[31:20]};
      IMM_S:   Imm_Ext = {{(XLEN-12){In[31]}}, In[31:25], In[11:7]};
      IMM_B:   Imm_Ext = {{(XLEN-12){In[31]}}, In[7], In[30:25], In[11:8], 1'b0};
      default: Imm_Ext = '0;
    endcase
  end
endmodule

// File: rtl/decode_stage_pipe_regfile.sv
// Register file with hard-wired x0 and async clear. Define DEC_BYPASS_EN for
// write-through: a same-cycle write is visible on a matching read port.
module dec_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);
  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`ifdef DEC_BYPASS_EN
    if (we_i && waddr_i != '0 && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (we_i && waddr_i != '0 && waddr_i == raddr2_i) rdata2_o = wdata_i;
`endif
  end
endmodule

// File: rtl/decode_stage_pipe.sv
// RISC-V decode stage: decode, register read, immediate extend and the D->E
// register with flush/stall/valid and load-use detection (DEC_BYPASS_EN in regfile).
module decode_stage_pipe
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = 32,
  parameter int unsigned ALUCW = ALUCW_DEF
) (
  input logic clk,
  input logic rst,
  decode_stage_pipe_if.slave dec
);
  localparam int unsigned AW = $clog2(NREGS);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             alusrc;
    logic             memwrite;
    logic             resultsrc;
    logic             branch;
    logic [ALUCW-1:0] aluctl;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pcplus4;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [AW-1:0]    rd;
  } ereg_t;

  localparam ereg_t EREG_BUBBLE = {$bits(ereg_t){BUBBLE}};

  ereg_t           ereg_q, ereg_d;
  logic [AW-1:0]   rs1_d, rs2_d, rd_d;
  logic            regwrite_d, alusrc_d, memwrite_d, resultsrc_d, branch_d;
  logic [1:0]      immsrc_d;
  logic [2:0]      aluctl_d;
  logic [XLEN-1:0] imm_d, rd1_d, rd2_d;

  assign rs1_d = dec.InstrD[15 +: AW];
  assign rs2_d = dec.InstrD[20 +: AW];
  assign rd_d  = dec.InstrD[7 +: AW];

  Control_Unit u_ctrl (
    .Op(dec.InstrD[6:0]), .funct3(dec.InstrD[14:12]), .funct7(dec.InstrD[31:25]),
    .RegWrite(regwrite_d), .ImmSrc(immsrc_d), .ALUSrc(alusrc_d), .MemWrite(memwrite_d),
    .ResultSrc(resultsrc_d), .Branch(branch_d), .ALUControl(aluctl_d)
  );

  Sign_Extend #(.XLEN(XLEN)) u_sext (
    .In(dec.InstrD), .ImmSrc(immsrc_d), .Imm_Ext(imm_d)
  );

  dec_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk_i(clk), .rst_ni(rst), .we_i(dec.RegWriteW), .waddr_i(dec.RDW),
    .wdata_i(dec.ResultW), .raddr1_i(rs1_d), .raddr2_i(rs2_d),
    .rdata1_o(rd1_d), .rdata2_o(rd2_d)
  );

  // Flush beats stall; an invalid D slot loads the same bubble as a flush.
  always_comb begin
    ereg_d = ereg_q;
    if (dec.FlushE) begin
      ereg_d = EREG_BUBBLE;
    end else if (!dec.StallD) begin
      if (!dec.ValidD) begin
        ereg_d = EREG_BUBBLE;
      end else begin
        ereg_d = '{valid: 1'b1, regwrite: regwrite_d, alusrc: alusrc_d,
                   memwrite: memwrite_d, resultsrc: resultsrc_d, branch: branch_d,
                   aluctl: ALUCW'(aluctl_d), rd1: rd1_d, rd2: rd2_d, imm: imm_d,
                   pc: dec.PCD, pcplus4: dec.PCPlus4D, rs1: rs1_d, rs2: rs2_d, rd: rd_d};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ereg_q <= EREG_BUBBLE;
    else      ereg_q <= ereg_d;
  end

  assign dec.HazardD = ereg_q.valid & ereg_q.resultsrc & ereg_q.regwrite &
                       (ereg_q.rd != '0) & ((ereg_q.rd == rs1_d) | (ereg_q.rd == rs2_d));

  assign dec.ValidE      = ereg_q.valid;
  assign dec.RegWriteE   = ereg_q.regwrite;
  assign dec.ALUSrcE     = ereg_q.alusrc;
  assign dec.MemWriteE   = ereg_q.memwrite;
  assign dec.ResultSrcE  = ereg_q.resultsrc;
  assign dec.BranchE     = ereg_q.branch;
  assign dec.ALUControlE = ereg_q.aluctl;
  assign dec.RD1_E       = ereg_q.rd1;
  assign dec.RD2_E       = ereg_q.rd2;
  assign dec.Imm_Ext_E   = ereg_q.imm;
  assign dec.PCE         = ereg_q.pc;
  assign dec.PCPlus4E    = ereg_q.pcplus4;
  assign dec.RS1_E       = ereg_q.rs1;
  assign dec.RS2_E       = ereg_q.rs2;
  assign dec.RD_E        = ereg_q.rd;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed-vector bench for decode_stage_pipe; expectations follow DEC_BYPASS_EN.
module tb_decode_stage_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] byp_exp;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.XLEN(32), .NREGS(32), .ALUCW(3)) dec ();

  decode_stage_pipe #(.XLEN(32), .NREGS(32), .ALUCW(3)) dut (
    .clk(clk), .rst(rst), .dec(dec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef DEC_BYPASS_EN
    byp_exp = 32'hDEADBEEF;
`else
    byp_exp = 32'h0;
`endif
    dec.InstrD = '0; dec.PCD = '0; dec.PCPlus4D = '0; dec.ValidD = 1'b0;
    dec.StallD = 1'b0; dec.FlushE = 1'b0; dec.RegWriteW = 1'b0; dec.RDW = '0;
    dec.ResultW = '0;

    #2;
    chk("rst_valid", dec.ValidE, 0);
    chk("rst_regwrite", dec.RegWriteE, 0);
    chk("rst_rd", dec.RD_E, 0);
    chk("rst_rd1", dec.RD1_E, 0);
    chk("rst_imm", dec.Imm_Ext_E, 0);
    chk("rst_pc", dec.PCE, 0);
    chk("rst_hazard", dec.HazardD, 0);

    @(negedge clk) rst = 1'b1;
    dec.InstrD = 32'h00700293; dec.ValidD = 1'b1;
    dec.PCD = 32'h100; dec.PCPlus4D = 32'h104;
    tick();
    chk("addi_valid", dec.ValidE, 1);
    chk("addi_regwrite", dec.RegWriteE, 1);
    chk("addi_alusrc", dec.ALUSrcE, 1);
    chk("addi_memwrite", dec.MemWriteE, 0);
    chk("addi_aluctl", dec.ALUControlE, 0);
    chk("addi_imm", dec.Imm_Ext_E, 7);
    chk("addi_rd", dec.RD_E, 5);
    chk("addi_rs1", dec.RS1_E, 0);
    chk("addi_rs2", dec.RS2_E, 7);
    chk("addi_rd1", dec.RD1_E, 0);
    chk("addi_pc", dec.PCE, 32'h100);
    chk("addi_pc4", dec.PCPlus4E, 32'h104);

    dec.StallD = 1'b1; dec.InstrD = 32'h00528333;
    dec.PCD = 32'h104; dec.PCPlus4D = 32'h108;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", dec.ValidE, 1);
      chk("stall_rd", dec.RD_E, 5);
      chk("stall_imm", dec.Imm_Ext_E, 7);
      chk("stall_pc", dec.PCE, 32'h100);
      chk("stall_alusrc", dec.ALUSrcE, 1);
    end
    dec.StallD = 1'b0;
    tick();
    chk("add_rd", dec.RD_E, 6);
    chk("add_rs1", dec.RS1_E, 5);
    chk("add_rs2", dec.RS2_E, 5);
    chk("add_alusrc", dec.ALUSrcE, 0);
    chk("add_regwrite", dec.RegWriteE, 1);
    chk("add_rd1", dec.RD1_E, 0);
    chk("add_pc", dec.PCE, 32'h104);
    chk("add_hazard", dec.HazardD, 0);

    dec.FlushE = 1'b1; dec.StallD = 1'b1;
    tick();
    chk("flush_valid", dec.ValidE, 0);
    chk("flush_regwrite", dec.RegWriteE, 0);
    chk("flush_memwrite", dec.MemWriteE, 0);
    chk("flush_imm", dec.Imm_Ext_E, 0);
    chk("flush_pc", dec.PCE, 0);
    chk("flush_rd", dec.RD_E, 0);
    chk("flush_rs1", dec.RS1_E, 0);
    dec.FlushE = 1'b0; dec.StallD = 1'b0;

    dec.RegWriteW = 1'b1; dec.RDW = 5'd5; dec.ResultW = 32'hDEADBEEF;
    tick();
    chk("wb_same_rd1", dec.RD1_E, byp_exp);
    chk("wb_same_rd2", dec.RD2_E, byp_exp);
    dec.RegWriteW = 1'b0;
    tick();
    chk("wb_reread_rd1", dec.RD1_E, 32'hDEADBEEF);
    chk("wb_reread_rd2", dec.RD2_E, 32'hDEADBEEF);

    dec.InstrD = 32'h00502223;
    tick();
    chk("sw_memwrite", dec.MemWriteE, 1);
    chk("sw_regwrite", dec.RegWriteE, 0);
    chk("sw_imm", dec.Imm_Ext_E, 4);
    chk("sw_rd2", dec.RD2_E, 32'hDEADBEEF);

    dec.InstrD = 32'h000003B3;
    dec.RegWriteW = 1'b1; dec.RDW = 5'd0; dec.ResultW = 32'h1234;
    tick();
    chk("x0_same_rd1", dec.RD1_E, 0);
    chk("x0_same_rd2", dec.RD2_E, 0);
    dec.RegWriteW = 1'b0;
    tick();
    chk("x0_later_rd1", dec.RD1_E, 0);
    chk("x0_later_rd2", dec.RD2_E, 0);

    dec.InstrD = 32'h00012083;
    tick();
    chk("lw_resultsrc", dec.ResultSrcE, 1);
    chk("lw_rd", dec.RD_E, 1);
    chk("lw_rs1", dec.RS1_E, 2);
    chk("lw_hazard_self", dec.HazardD, 0);
    dec.StallD = 1'b1;
    dec.InstrD = 32'h00108133;
    #1 chk("hz_rs1_rs2", dec.HazardD, 1);
    dec.InstrD = 32'h003181B3;
    #1 chk("hz_x3_only", dec.HazardD, 0);
    dec.InstrD = 32'h001181B3;
    #1 chk("hz_rs2_only", dec.HazardD, 1);

    dec.StallD = 1'b0; dec.ValidD = 1'b0; dec.InstrD = 32'h00108133;
    tick();
    chk("nv_valid", dec.ValidE, 0);
    chk("nv_rd", dec.RD_E, 0);
    chk("nv_hazard", dec.HazardD, 0);

    dec.ValidD = 1'b1; dec.InstrD = 32'h00528333;
    tick();
    chk("pre_rst_rd1", dec.RD1_E, 32'hDEADBEEF);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", dec.ValidE, 0);
    chk("arst_rd1", dec.RD1_E, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("post_rst_valid", dec.ValidE, 1);
    chk("post_rst_rd1", dec.RD1_E, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised next-generation decode stage of the 5-stage RISC-V core. It decodes InstrD, reads the register file and extends the immediate.
- Registers everything into the D->E pipeline register, which supports stall, flush, per-instruction valid and load-use hazard detection.
- Sits between fetch_cycle and execute_cycle. Writeback drives the register-file write port.

Parameters:
- XLEN, 32, datapath width (PC, register data, immediate).
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- AW, $clog2(NREGS), register index width (derived; do not override).
- ALUCW, 3, ALU control width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-low reset.
- InstrD  in  32  instruction in decode.
- PCD  in  XLEN  PC of InstrD.
- PCPlus4D  in  XLEN  PC+4 of InstrD.
- ValidD  in  1  InstrD is a real instruction.
- StallD  in  1  hold the E register.
- FlushE  in  1  insert a bubble into E.
- RegWriteW  in  1  writeback write enable.
- RDW  in  AW  writeback destination.
- ResultW  in  XLEN  writeback data.
- HazardD  out  1  load-use hazard detected (combinational).
- ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  registered controls.
- ALUControlE  out  ALUCW  registered ALU op.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN  registered data.
- RS1_E, RS2_E, RD_E  out  AW  registered register indices: InstrD[15+:AW], [20+:AW], [7+:AW].

Behaviour:
- Reset (rst=0, async): every E output is 0 and all register-file entries are 0. HazardD is 0 because ValidE=0.
- Decode is combinational in D: Control_Unit (op, funct3, funct7) and Sign_Extend (ImmSrc). Register reads are combinational.
- Latency: one cycle D->E.
- E register update priority at posedge, highest first:
  - FlushE=1: load a bubble. All E outputs go to 0, including data and indices.
  - StallD=1: hold all E outputs.
  - ValidD=0: load a bubble (same as flush).
  - Otherwise: capture the decoded values with ValidE=1.
- FlushE and StallD asserted together: the flush wins and the bubble is loaded.
- Register file:
  - NREGS x XLEN entries, written at posedge when RegWriteW=1 and RDW!=0.
  - Writes to index 0 are ignored; reads of index 0 always return 0.
  - Reset mid-operation clears all entries immediately.
- HazardD = ValidE & ResultSrcE & RegWriteE & (RD_E!=0) & ((RD_E==RS1_D) | (RD_E==RS2_D)).
  - RS1_D and RS2_D are the live InstrD fields; both are compared regardless of instruction format.
  - The hazard unit drives StallD and FlushE from HazardD. This block does not self-stall.
- A stalled E register does not re-read the register file. Captured RD1_E and RD2_E stay frozen.

Optional Feature:
- Macro DEC_BYPASS_EN.
- Defined: write-through bypass. When RegWriteW=1, RDW!=0 and RDW equals a read index, that read returns ResultW in the same cycle, so the E register captures the new value.
- Undefined: reads return the pre-write array value. A same-cycle W->D dependency must then be resolved by the hazard unit (extra stall).

Decomposition:
- Shared package core_pkg holds:
  - the XLEN and ALUCW defaults;
  - opcode constants (OP_LOAD 7'b0000011, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH);
  - the ImmSrc encodings;
  - the ALU control encodings;
  - a BUBBLE constant of all zeros for the E register.
- One sub-module, dec_regfile: parametrised by XLEN and NREGS, holds the x0 rule and the DEC_BYPASS_EN bypass.
- Control_Unit and Sign_Extend are instantiated unchanged.

Test Plan:
- Reset, then release with InstrD=0x00700293 (addi x5,x0,7) and ValidD=1 -> next cycle ValidE=1, RegWriteE=1, ALUSrcE=1, Imm_Ext_E=7, RD_E=5, RS1_E=0, RD1_E=0.
- Hold StallD=1 for 3 cycles while changing InstrD to 0x00528333 -> all E outputs stay as in the previous scenario; on release, RD_E=6, RS1_E=RS2_E=5.
- Assert FlushE=1 and StallD=1 in the same cycle -> next cycle ValidE=0, RegWriteE=0, MemWriteE=0, all data 0.
- RegWriteW=1, RDW=5, ResultW=0xDEADBEEF in the same cycle as decoding 0x00528333:
  - with DEC_BYPASS_EN -> RD1_E=RD2_E=0xDEADBEEF next cycle;
  - without -> RD1_E=0, and 0xDEADBEEF appears only after a re-read.
- Write RDW=0, ResultW=0x1234 -> a later read of x0 returns 0.
- E holds lw x1,0(x2) (0x00012083) with InstrD=0x00108133 (add x2,x1,x1) -> HazardD=1; with InstrD using x3 only, HazardD=0.
